// File: rtl/data_memory_responder_if.sv
// Request/response bus between the MIPS control path and the data-memory responder.
interface data_memory_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  MemReady;
  logic                  MemBusy;
  logic                  MemError;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, MemReady, MemBusy, MemError
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, MemReady, MemBusy, MemError
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed block-RAM responder with a programmable read wait-state and a one-cycle ready pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject byte-misaligned requests with MemError.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READ_WAIT  = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  data_memory_responder_if.slave   memBus
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESPOND   = 2'd2
  } stateT;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  stateT                 state, nextState;
  logic [CNT_WIDTH-1:0]  cnt, cntNext;
  logic [ADDR_WIDTH-1:0] idx, idxNext, readIdx, addrIdx;
  logic                  memWe, ramRe;
  logic                  readyNext, busyNext, errorNext;
  logic                  aligned, reqWrite, reqRead, reqErr;
  logic                  unusedAddrBits;

  assign addrIdx        = memBus.Address[ADDR_WIDTH+1:2];
  assign unusedAddrBits = ^{memBus.Address[31:ADDR_WIDTH+2], memBus.Address[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign aligned = (memBus.Address[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  // Request decode, only meaningful while idle
  assign reqWrite = memBus.MemWrite & ~memBus.MemRead & aligned;
  assign reqRead  = memBus.MemRead & ~memBus.MemWrite & aligned;
  assign reqErr   = (memBus.MemRead & memBus.MemWrite)
                  | ((memBus.MemRead | memBus.MemWrite) & ~aligned);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      idx             <= '0;
      memBus.ReadData <= '0;
      memBus.MemReady <= 1'b0;
      memBus.MemBusy  <= 1'b0;
      memBus.MemError <= 1'b0;
    end else begin
      state           <= nextState;
      cnt             <= cntNext;
      idx             <= idxNext;
      memBus.MemReady <= readyNext;
      memBus.MemBusy  <= busyNext;
      memBus.MemError <= errorNext;
      if (ramRe) begin
        memBus.ReadData <= mem[readIdx];
      end
    end
  end

  // RAM array is not reset; a write is suppressed on a reset edge
  always_ff @(posedge CLK) begin
    if (Reset && memWe) begin
      mem[addrIdx] <= memBus.WriteData;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (reqWrite) begin
          nextState = ST_RESPOND;
        end else if (reqRead) begin
          nextState = (READ_WAIT == 0) ? ST_RESPOND : ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (cnt == CNT_WIDTH'(1)) begin
          nextState = ST_RESPOND;
        end
      end
      ST_RESPOND: nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    memWe     = 1'b0;
    ramRe     = 1'b0;
    cntNext   = cnt;
    idxNext   = idx;
    readIdx   = idx;
    errorNext = 1'b0;
    readyNext = (nextState == ST_RESPOND);
    busyNext  = (nextState != ST_IDLE);
    case (state)
      ST_IDLE: begin
        errorNext = reqErr;
        if (reqWrite) begin
          memWe = 1'b1;
        end else if (reqRead) begin
          idxNext = addrIdx;
          cntNext = CNT_WIDTH'(READ_WAIT);
          if (READ_WAIT == 0) begin
            ramRe   = 1'b1;
            readIdx = addrIdx;
          end
        end
      end
      ST_READ_WAIT: begin
        cntNext = cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) begin
          ramRe = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
